// File: rtl/park_pkg.sv
// park_pkg
//   Shared constants and types for the parking slot manager.
//   SLOTS / SLOT_W   : lot size and slot index width (matches the encoder).
//   GATE_CYCLES_DEF  : default number of cycles the entry gate stays open.
//   park_state_t     : entry FSM states.
package park_pkg;

  localparam int SLOTS           = 8;
  localparam int SLOT_W          = 3;
  localparam int GATE_CYCLES_DEF = 4;

  typedef enum logic {
    IDLE      = 1'b0,
    GATE_OPEN = 1'b1
  } park_state_t;

endpackage

// File: rtl/park_gate_timer.sv
// park_gate_timer
//   Load/decrement counter that times the entry gate.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     load       : load the counter with cycles (one-cycle strobe)
//     cycles     : open duration, 1..15
//     active     : counter non-zero (drives gate_open)
//     last       : counter equals 1, i.e. this is the final open cycle
module park_gate_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] cycles,
  output logic       active,
  output logic       last
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= cycles;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign active = (count != 4'd0);
  assign last   = (count == 4'd1);

endmodule

// File: rtl/park_slot_manager.sv
// park_slot_manager
//   Owns the 8-slot free vector feeding the external priority encoder,
//   grants entries, handles exits and times the entry gate.
//   Optional feature macro: PARK_STATS_EN (adds entry_total / reject_total).
//   Ports:
//     clk, reset       : clock, synchronous active-high reset
//     enter_req        : car waiting at entry
//     exit_valid       : one-cycle strobe, car leaving exit_slot
//     exit_slot        : slot being vacated
//     park_number      : encoder result (highest free slot)
//     parking_capacity : free vector, bit i = 1 means slot i free
//     enable           : OR of parking_capacity (encoder enable)
//     enter_ack        : one-cycle grant pulse
//     assigned_slot    : slot granted, held until the next grant
//     full_reject      : one-cycle refusal pulse (lot full)
//     exit_error       : one-cycle pulse, exit of an already free slot
//     gate_open        : entry gate drive
//     free_count       : number of free slots, 0..8
//     state_dbg        : current FSM state (0 = IDLE, 1 = GATE_OPEN)
//     entry_total      : (PARK_STATS_EN) saturating count of grants
//     reject_total     : (PARK_STATS_EN) saturating count of refusals
//
//   Handshake: enter_req is a level held by the requester until it sees
//   either enter_ack or full_reject; each answer is a single-cycle pulse
//   one cycle after the request is seen in IDLE. Requests are not looked at
//   while the gate is open.
module park_slot_manager
  import park_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_req,
  input  logic       exit_valid,
  input  logic [2:0] exit_slot,
  input  logic [2:0] park_number,
  output logic [7:0] parking_capacity,
  output logic       enable,
  output logic       enter_ack,
  output logic [2:0] assigned_slot,
  output logic       full_reject,
  output logic       exit_error,
  output logic       gate_open,
`ifdef PARK_STATS_EN
  output logic [15:0] entry_total,
  output logic [7:0]  reject_total,
`endif
  output logic [3:0] free_count,
  output logic       state_dbg
);

  localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES);

  park_state_t state, state_next;
  logic        grant, reject;
  logic        exit_legal, exit_bad;
  logic        gate_last;
  logic [7:0]  cap_next;
  logic [3:0]  count_next;

  assign enable    = |parking_capacity;
  assign state_dbg = state;

  park_gate_timer u_gate_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (grant),
    .cycles (GATE_LOAD),
    .active (gate_open),
    .last   (gate_last)
  );

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (enter_req) begin
          if (enable) begin
            grant      = 1'b1;
            state_next = GATE_OPEN;
          end else if (!full_reject) begin
            // Skipping the cycle right after a refusal gives the requester
            // time to drop enter_req; a held request re-pulses every 2nd cycle.
            reject = 1'b1;
          end
        end
      end
      GATE_OPEN: begin
        if (gate_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Exit decisions use the pre-update vector. A legal exit targets an
  // occupied slot, and a grant targets a free one, so they never collide.
  always_comb begin
    exit_legal = exit_valid && !parking_capacity[exit_slot];
    exit_bad   = exit_valid &&  parking_capacity[exit_slot];
    cap_next   = parking_capacity;
    if (grant)      cap_next[park_number] = 1'b0;
    if (exit_legal) cap_next[exit_slot]   = 1'b1;
    case ({grant, exit_legal})
      2'b10:   count_next = free_count - 4'd1;
      2'b01:   count_next = free_count + 4'd1;
      default: count_next = free_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      parking_capacity <= 8'hFF;
      free_count       <= 4'd8;
      assigned_slot    <= 3'd0;
      enter_ack        <= 1'b0;
      full_reject      <= 1'b0;
      exit_error       <= 1'b0;
    end else begin
      state            <= state_next;
      parking_capacity <= cap_next;
      free_count       <= count_next;
      enter_ack        <= grant;
      full_reject      <= reject;
      exit_error       <= exit_bad;
      if (grant) assigned_slot <= park_number;
    end
  end

`ifdef PARK_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_total  <= 16'd0;
      reject_total <= 8'd0;
    end else begin
      if (enter_ack && (entry_total != 16'hFFFF))  entry_total  <= entry_total + 16'd1;
      if (full_reject && (reject_total != 8'hFF))  reject_total <= reject_total + 8'd1;
    end
  end
`endif

endmodule
